seq_hit_window_counter: RTL

//  Downstream consumer of the sequence detector's one-cycle match output (out_seq).

---
 rtl/seq_hit_window_counter_pkg.sv | 15 +
 rtl/seq_hit_window_counter_if.sv | 30 +++
 rtl/seq_hit_window_counter_sat_accum.sv | 45 ++++
 rtl/seq_hit_window_counter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/seq_hit_window_counter_pkg.sv
// Shared definitions for the hit window counter slice.
//   state_t      : FSM state encoding
//   DEF_CNT_W    : default per-window hit count width
//   DEF_WIN_W    : default window-length width
package seq_hit_window_counter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/seq_hit_window_counter_if.sv
// Report port between the window counter and the host/CSR consumer.
//   rpt_valid : report holding register holds an unread count
//   rpt_ready : consumer accepts when rpt_valid & rpt_ready
//   rpt_count : hits counted in the reported window
//   rpt_sat   : reported count saturated
// master = window counter side, slave = consumer side.
interface seq_hit_window_counter_if #(
  parameter int CNT_W = 8
);

  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_sat;

  modport master (
    output rpt_valid,
    output rpt_count,
    output rpt_sat,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_count,
    input  rpt_sat,
    output rpt_ready
  );

endinterface

// File: rtl/seq_hit_window_counter_sat_accum.sv
// CNT_W-bit saturating hit accumulator.
//   clk, reset : clock, async active-low reset
//   clr        : clear accumulator and sat flag (dominates inc)
//   inc        : count one hit this cycle
//   count      : accumulated value including this cycle's inc
//   sat_flag   : an increment past max was attempted, including this cycle's
// Exposing the post-increment value lets a hit on the last window cycle be
// reported in the same cycle the accumulator is cleared.
module seq_hit_window_counter_sat_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat_flag
);

  logic [CNT_W-1:0] acc_q;
  logic             sat_q;

  always_comb begin
    count    = acc_q;
    sat_flag = sat_q;
    if (inc) begin
      if (&acc_q) sat_flag = 1'b1;
      else        count    = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= count;
      sat_q <= sat_flag;
    end
  end

endmodule

// File: rtl/seq_hit_window_counter.sv
// Counts detector hits over programmable windows and hands each window's
// count to a consumer through a valid/ready report register.
//   clk, reset : clock, async active-low reset
//   enable     : run back-to-back windows; 0 stops/abandons the window
//   win_len    : window length in cycles, latched at window start (0 -> 1)
//   hit_in     : detector match strobe, sampled every cycle
//   ovf_clr    : synchronous clear of ovf_sticky
//   ovf_sticky : a window result was dropped because the report was full
//   busy       : 1 while counting
//   rpt        : report port (valid/ready, count, sat)
//
// state    | meaning
// ST_IDLE  | waiting for enable, accumulator clear
// ST_COUNT | counting hits, timer counts down to 0 on the last window cycle
module seq_hit_window_counter
  import seq_hit_window_counter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [WIN_W-1:0]         win_len,
  input  logic                     hit_in,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky,
  output logic                     busy,
  seq_hit_window_counter_if.master rpt
);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [WIN_W-1:0] load_val;
  logic             win_last;
  logic             acc_clr;
  logic             acc_inc;
  logic [CNT_W-1:0] acc_res;
  logic             acc_sat;

  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  logic             sat_q;
  logic             ovf_q;
  logic             accept;
  logic             drop;

  // A zero length runs as a one-cycle window.
  assign load_val = (win_len == '0) ? '0 : win_len - WIN_W'(1);
  assign win_last = (state_q == ST_COUNT) && (timer_q == '0);
  assign acc_inc  = hit_in && (state_q == ST_COUNT);

  seq_hit_window_counter_sat_accum #(.CNT_W(CNT_W)) u_accum (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr),
    .inc      (acc_inc),
    .count    (acc_res),
    .sat_flag (acc_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    acc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_COUNT;
          timer_d = load_val;
        end
      end
      ST_COUNT: begin
        if (win_last) begin
          // Result is taken this cycle; back-to-back window if still enabled.
          acc_clr = 1'b1;
          if (enable) begin
            timer_d = load_val;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!enable) begin
          acc_clr = 1'b1;
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - WIN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        acc_clr = 1'b1;
      end
    endcase
  end

  assign accept = valid_q && rpt.rpt_ready;
  assign drop   = win_last && valid_q && !accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (win_last && (!valid_q || accept)) begin
        valid_q <= 1'b1;
        count_q <= acc_res;
        sat_q   <= acc_sat;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_count = count_q;
  assign rpt.rpt_sat   = sat_q;
  assign ovf_sticky    = ovf_q;
  assign busy          = (state_q == ST_COUNT);

endmodule
